req_pending_queue: RTL and testbench
====================================

// Module: req_pending_queue
// PURPOSE
//  Upstream stage of the 4-port fixed-priority arbiter. Holds a per-port count
//  of outstanding request pulses and presents req_o[i]=1 while port i has any
//  pending request. Consumes the arbiter's one-hot grant to retire one pending
//  request per grant cycle, so bursty requesters are not lost between grants.
// PARAMETERS
//  NUM_PORTS  4   number of requester ports; equals arbiter width
//  DEPTH      7   max pending requests per port (>=1)
//  CW         $clog2(DEPTH+1)  derived, localparam; per-port counter width
// PORTS
//  clk      in   1              single clock, all logic on posedge
//  reset    in   1              synchronous, active-high
//  push_i   in   NUM_PORTS      per-port request pulse, one request per cycle high
//  ready_o  out  NUM_PORTS      port i can accept a push (count<DEPTH)
//  req_o    out  NUM_PORTS      to arbiter req_i; bit i = (count_i!=0)
//  gnt_i    in   NUM_PORTS      from arbiter gnt_o; one-hot or zero
//  count_o  out  NUM_PORTS*CW   packed per-port counts, port i at [i*CW +: CW]
//  ovf_o    out  NUM_PORTS      sticky: push dropped on a full port
//  err_o    out  1              sticky grant-protocol error (GNT_CHECK_EN only)
// BEHAVIOUR
//  - Reset (sync, high): all counts=0, req_o=0, ready_o=all 1, ovf_o=0, err_o=0.
//    Reset dominates push/gnt in the same cycle; mid-operation reset discards
//    all pending requests.
//  - Per port i, at each posedge (reset low):
//      push&~gnt: count+1 if count<DEPTH, else dropped and ovf_o[i]<=1
//      gnt&~push: count-1 if count>0, else ignored (no underflow)
//      push&gnt : count unchanged, even when full (retire frees the slot);
//                 if count==0, the net result is count 1 (the grant is ignored)
//      neither  : hold
//  - req_o, ready_o: combinational decode of registered counts only, so there is
//    no combinational path gnt_i->req_o and no loop with the combinational arbiter.
//  - Latency: push at edge t -> req_o high after edge t (cycle t+1).
//    Grant in cycle t -> count drops at edge t+1; req_o falls then if count hit 0.
//  - ready_o[i]=0 only when count==DEPTH. Pushing while ready_o low is legal but
//    drops the request (see ovf_o).
//  - ovf_o bits clear only on reset.
//  - Counter arithmetic is unsigned CW-bit, saturating at 0 and DEPTH; never wraps.
// CONFIGURATION
//  Macro GNT_CHECK_EN:
//   defined  : err_o sets (sticky) when gnt_i has >1 bit set, or when gnt_i[i]=1
//              with req_o[i]=0. The offending grant bits are ignored for
//              counting in that cycle.
//   undefined: no checker; err_o tied 0; one-hot gnt_i is trusted and each set
//              bit is applied independently.
// STRUCTURE
//  - Package arb_pkg: NUM_PORTS_DEF=4, typedef logic [NUM_PORTS_DEF-1:0] port_vec_t,
//    shared with the arbiter and its bench.
//  - Sub-module req_port_counter (DEPTH param): one saturating up/down counter
//    with full/ovf logic. Instantiated NUM_PORTS times in a generate loop.
//  - Top holds the packing of count_o and the optional grant checker.
// TESTING
//  1. Reset: push_i=4'hF with reset=1 for 2 cycles -> counts 0, req_o=0, ready_o=F.
//  2. Fill/overflow: push_i[2]=1 for 8 cycles, gnt_i=0 -> count2=7, ready_o[2]=0
//     after 7th edge, ovf_o[2]=1 after 8th, req_o=4'b0100.
//  3. Drain: arbiter model on req_o, no pushes, all 4 ports at count 3 -> 12 grant
//     cycles, port 0 drained first, then ports 1, 2, 3; req_o=0 after the 12th edge.
//  4. Simultaneous: count1=DEPTH, push_i[1]=1 & gnt_i[1]=1 -> count stays 7,
//     ovf_o[1] stays 0. count3=0, push&gnt -> count3=1.
//  5. Mid-op reset: counts {2,5,1,7}, reset 1 cycle -> all 0, ovf_o=0 next cycle.
//  6. GNT_CHECK_EN: gnt_i=4'b0011 -> err_o=1 sticky, counts unchanged;
//     gnt_i=4'b1000 with count3=0 -> err_o=1. Without macro: err_o always 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types for the 4-port fixed-priority arbiter and its upstream queue.
// Build option: GNT_CHECK_EN enables the grant-protocol checker in req_pending_queue.
package arb_pkg;
  localparam int NUM_PORTS_DEF = 4;
  localparam int DEPTH_DEF = 7;
  typedef logic [NUM_PORTS_DEF-1:0] port_vec_t;
endpackage

// File: rtl/req_port_counter.sv
// One port's pending-request counter.
// Saturates at 0 and DEPTH; a dropped push sets a sticky overflow flag.
module req_port_counter #(
  parameter int DEPTH = 7,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          gnt_i,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          ovf_o
);
  localparam logic [CW-1:0] MAX = CW'(DEPTH);

  logic [CW-1:0] r_cnt;
  logic          r_ovf;

  // Count pushes up and grants down; push+grant leaves a busy port unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      unique case ({push_i, gnt_i})
        2'b10: begin
          if (r_cnt != MAX) r_cnt <= r_cnt + 1'b1;
          else r_ovf <= 1'b1;
        end
        2'b01: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        2'b11: begin
          if (r_cnt == '0) r_cnt <= CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign count_o = r_cnt;
  assign full_o  = (r_cnt == MAX);
  assign ovf_o   = r_ovf;
endmodule

// File: rtl/req_pending_queue.sv
// Per-port pending-request queue feeding the fixed-priority arbiter.
// Build option: GNT_CHECK_EN adds a sticky grant-protocol error flag.
module req_pending_queue
  import arb_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_PORTS-1:0]   push_i,
  output logic [NUM_PORTS-1:0]   ready_o,
  output logic [NUM_PORTS-1:0]   req_o,
  input  logic [NUM_PORTS-1:0]   gnt_i,
  output logic [NUM_PORTS*CW-1:0] count_o,
  output logic [NUM_PORTS-1:0]   ovf_o,
  output logic                   err_o
);
  logic [NUM_PORTS-1:0] w_gnt;
  logic [NUM_PORTS-1:0] w_full;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    logic [CW-1:0] w_cnt;

    req_port_counter #(.DEPTH(DEPTH)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_i[i]),
      .gnt_i   (w_gnt[i]),
      .count_o (w_cnt),
      .full_o  (w_full[i]),
      .ovf_o   (ovf_o[i])
    );

    assign count_o[i*CW +: CW] = w_cnt;
    assign req_o[i] = (w_cnt != '0);
  end

  assign ready_o = ~w_full;

`ifdef GNT_CHECK_EN
  logic                 w_multi;
  logic [NUM_PORTS-1:0] w_bad;
  logic                 r_err;

  assign w_multi = |(gnt_i & (gnt_i - 1'b1));
  assign w_bad   = gnt_i & ~req_o;
  assign w_gnt   = w_multi ? '0 : (gnt_i & req_o);

  // Latch any multi-hot grant or grant to an idle port until reset.
  always_ff @(posedge clk) begin
    if (reset) r_err <= 1'b0;
    else if (w_multi || (|w_bad)) r_err <= 1'b1;
  end

  assign err_o = r_err;
`else
  assign w_gnt = gnt_i;
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_req_pending_queue.sv
// Directed bench for req_pending_queue: vector table plus corner sequences.
// Checker expectations follow GNT_CHECK_EN when that macro is defined.
module tb_req_pending_queue;
  import arb_pkg::*;

`ifdef GNT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [3:0]  push_i;
  logic [3:0]  ready_o;
  logic [3:0]  req_o;
  logic [3:0]  gnt_i;
  logic [11:0] count_o;
  logic [3:0]  ovf_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  req_pending_queue dut (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_i),
    .ready_o (ready_o),
    .req_o   (req_o),
    .gnt_i   (gnt_i),
    .count_o (count_o),
    .ovf_o   (ovf_o),
    .err_o   (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    logic [3:0] push;
    logic [3:0] gnt;
    logic [2:0] c3, c2, c1, c0;
    logic [3:0] ovf;
    bit         err;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input bit rst, input logic [3:0] p, input logic [3:0] g);
    @(negedge clk);
    reset = rst;
    push_i = p;
    gnt_i = g;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag,
                             input logic [2:0] c3, input logic [2:0] c2,
                             input logic [2:0] c1, input logic [2:0] c0,
                             input logic [3:0] ovf, input bit err);
    logic [2:0] c[4];
    logic [3:0] er, ed;
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    for (int i = 0; i < 4; i++) begin
      er[i] = (c[i] != 3'd0);
      ed[i] = (c[i] != 3'd7);
    end
    chk({tag, ".count"}, 32'(count_o), 32'({c3, c2, c1, c0}));
    chk({tag, ".req"}, 32'(req_o), 32'(er));
    chk({tag, ".ready"}, 32'(ready_o), 32'(ed));
    chk({tag, ".ovf"}, 32'(ovf_o), 32'(ovf));
    chk({tag, ".err"}, 32'(err_o), 32'(CHK & err));
  endtask

  initial begin
    logic [3:0] g;
    logic [3:0] p;
    reset = 1'b1;
    push_i = 4'h0;
    gnt_i = 4'h0;

    tbl[0]  = '{1, 4'hF, 4'h0, 0, 0, 0, 0, 4'h0, 0};
    tbl[1]  = '{1, 4'hF, 4'h0, 0, 0, 0, 0, 4'h0, 0};
    tbl[2]  = '{0, 4'h4, 4'h0, 0, 1, 0, 0, 4'h0, 0};
    tbl[3]  = '{0, 4'h4, 4'h0, 0, 2, 0, 0, 4'h0, 0};
    tbl[4]  = '{0, 4'h4, 4'h0, 0, 3, 0, 0, 4'h0, 0};
    tbl[5]  = '{0, 4'h4, 4'h0, 0, 4, 0, 0, 4'h0, 0};
    tbl[6]  = '{0, 4'h4, 4'h0, 0, 5, 0, 0, 4'h0, 0};
    tbl[7]  = '{0, 4'h4, 4'h0, 0, 6, 0, 0, 4'h0, 0};
    tbl[8]  = '{0, 4'h4, 4'h0, 0, 7, 0, 0, 4'h0, 0};
    tbl[9]  = '{0, 4'h4, 4'h0, 0, 7, 0, 0, 4'h4, 0};
    tbl[10] = '{0, 4'h0, 4'h4, 0, 6, 0, 0, 4'h4, 0};
    tbl[11] = '{0, 4'h4, 4'h4, 0, 6, 0, 0, 4'h4, 0};
    tbl[12] = '{0, 4'h0, 4'h1, 0, 6, 0, 0, 4'h4, 1};
    tbl[13] = '{0, 4'h1, 4'h1, 0, 6, 0, 1, 4'h4, 1};
    tbl[14] = '{0, 4'hB, 4'h0, 1, 6, 1, 2, 4'h4, 1};
    tbl[15] = '{0, 4'h0, 4'h8, 0, 6, 1, 2, 4'h4, 1};
    tbl[16] = '{0, 4'h0, 4'h8, 0, 6, 1, 2, 4'h4, 1};
    tbl[17] = '{1, 4'hF, 4'hF, 0, 0, 0, 0, 4'h0, 0};

    for (int k = 0; k < 18; k++) begin
      step(tbl[k].rst, tbl[k].push, tbl[k].gnt);
      check_state($sformatf("vec%0d", k), tbl[k].c3, tbl[k].c2,
                  tbl[k].c1, tbl[k].c0, tbl[k].ovf, tbl[k].err);
    end

    // Drain: all ports at 3, lowest-index-first arbiter on req_o.
    step(1, 4'h0, 4'h0);
    for (int k = 0; k < 3; k++) step(0, 4'hF, 4'h0);
    check_state("drain_fill", 3, 3, 3, 3, 4'h0, 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      g = 4'h0;
      for (int i = 3; i >= 0; i--) if (req_o[i]) g = 4'(1 << i);
      chk($sformatf("drain_gnt%0d", k), 32'(g), 32'(1 << (k / 3)));
      reset = 1'b0;
      push_i = 4'h0;
      gnt_i = g;
      @(posedge clk);
      #1;
    end
    check_state("drain_end", 0, 0, 0, 0, 4'h0, 0);

    // Push and grant together on a full port and on an empty port.
    for (int k = 0; k < 7; k++) step(0, 4'h2, 4'h0);
    check_state("sim_full", 0, 0, 7, 0, 4'h0, 0);
    step(0, 4'h2, 4'h2);
    check_state("sim_pg_full", 0, 0, 7, 0, 4'h0, 0);
    step(0, 4'h8, 4'h8);
    check_state("sim_pg_empty", 1, 0, 7, 0, 4'h0, 1);

    // Mid-operation reset from counts {2,5,1,7} with ovf on port 3.
    step(1, 4'h0, 4'h0);
    for (int k = 0; k < 7; k++) begin
      p = {1'b1, (k < 1), (k < 5), (k < 2)};
      step(0, p, 4'h0);
    end
    step(0, 4'h8, 4'h0);
    check_state("mid_pre", 7, 1, 5, 2, 4'h8, 0);
    step(1, 4'hF, 4'hF);
    check_state("mid_rst", 0, 0, 0, 0, 4'h0, 0);
    step(0, 4'h0, 4'h0);
    check_state("mid_post", 0, 0, 0, 0, 4'h0, 0);

`ifdef GNT_CHECK_EN
    step(0, 4'hF, 4'h0);
    step(0, 4'hF, 4'h0);
    step(0, 4'h0, 4'h3);
    check_state("chk_multi", 2, 2, 2, 2, 4'h0, 1);
    step(0, 4'h0, 4'h0);
    check_state("chk_sticky", 2, 2, 2, 2, 4'h0, 1);
    step(1, 4'h0, 4'h0);
    check_state("chk_rst", 0, 0, 0, 0, 4'h0, 0);
    step(0, 4'h0, 4'h8);
    check_state("chk_idle", 0, 0, 0, 0, 4'h0, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
